// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } stateT;

    // Word-offset bits within a line.
    function automatic int unsigned offBits(input int unsigned blockWords);
        return $clog2(blockWords);
    endfunction

    // Line-index bits.
    function automatic int unsigned idxBits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag bits: whatever remains of the 30-bit word address.
    function automatic int unsigned tagBits(input int unsigned lines, input int unsigned blockWords);
        return 30 - offBits(blockWords) - idxBits(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port,
// valid bits cleared on reset (tag and data are left untouched).
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int unsigned LINES       = 64,
    parameter  int unsigned BLOCK_WORDS = 4,
    localparam int unsigned OFF_W       = offBits(BLOCK_WORDS),
    localparam int unsigned IDX_W       = idxBits(LINES),
    localparam int unsigned TAG_W       = tagBits(LINES, BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rdIdx,
    input  logic [OFF_W-1:0]  rdOff,
    output logic              rdValid,
    output logic [TAG_W-1:0]  rdTag,
    output logic [WORD_W-1:0] rdWord,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [OFF_W-1:0]  wrOff,
    input  logic              wordWe,
    input  logic [WORD_W-1:0] wrWord,
    input  logic              lineWe,
    input  logic [TAG_W-1:0]  wrTag
);

    logic [LINES-1:0]  validBits;
    logic [TAG_W-1:0]  tagMem  [LINES];
    logic [WORD_W-1:0] dataMem [LINES*BLOCK_WORDS];

    // Combinational read of the addressed line's valid, tag and word.
    always_comb begin
        rdValid = validBits[rdIdx];
        rdTag   = tagMem[rdIdx];
        rdWord  = dataMem[{rdIdx, rdOff}];
    end

    // Valid bits: cleared by reset, set when a completed line is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            validBits <= '0;
        end else if (lineWe) begin
            validBits[wrIdx] <= 1'b1;
        end
    end

    // Tag and data writes; these arrays are not reset.
    always_ff @(posedge clk) begin
        if (lineWe) begin
            tagMem[wrIdx] <= wrTag;
        end
        if (wordWe) begin
            dataMem[{wrIdx, wrOff}] <= wrWord;
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// MEM stage and a handshaked main memory.
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int unsigned LINES       = 64,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned OFF_W = offBits(BLOCK_WORDS);
    localparam int unsigned IDX_W = idxBits(LINES);
    localparam int unsigned TAG_W = tagBits(LINES, BLOCK_WORDS);

    stateT             state;
    stateT             nextState;
    logic [OFF_W-1:0]  beat;

    logic [TAG_W-1:0]  addrTag;
    logic [IDX_W-1:0]  addrIdx;
    logic [OFF_W-1:0]  addrOff;
    logic [1:0]        unusedAddrBits;

    logic              rdValid;
    logic [TAG_W-1:0]  rdTag;
    logic [WORD_W-1:0] rdWord;
    logic              hit;

    logic              wordWe;
    logic [OFF_W-1:0]  wrOff;
    logic [WORD_W-1:0] wrWord;
    logic              lineWe;

    assign addrTag        = cpu_addr[31 -: TAG_W];
    assign addrIdx        = cpu_addr[2+OFF_W +: IDX_W];
    assign addrOff        = cpu_addr[2 +: OFF_W];
    assign unusedAddrBits = cpu_addr[1:0];

    dcache_array #(
        .LINES       (LINES),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) uArray (
        .clk     (clk),
        .rst     (rst),
        .rdIdx   (addrIdx),
        .rdOff   (addrOff),
        .rdValid (rdValid),
        .rdTag   (rdTag),
        .rdWord  (rdWord),
        .wrIdx   (addrIdx),
        .wrOff   (wrOff),
        .wordWe  (wordWe),
        .wrWord  (wrWord),
        .lineWe  (lineWe),
        .wrTag   (addrTag)
    );

    assign hit       = rdValid && (rdTag == addrTag);
    assign cpu_rdata = rdWord;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Refill beat counter: advances per accepted beat, wraps to 0 after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (state == FILL && mem_ready) begin
            beat <= beat + OFF_W'(1);
        end else if (state == IDLE) begin
            beat <= '0;
        end
    end

    // Next-state, stall, memory-side outputs and array write controls.
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {cpu_addr[31:2], 2'b00};
        mem_wdata = cpu_wdata;
        wordWe    = 1'b0;
        wrOff     = addrOff;
        wrWord    = cpu_wdata;
        lineWe    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_wr) begin
                    stall     = 1'b1;
                    nextState = WRITE;
                end else if (cpu_rd && !hit) begin
                    stall     = 1'b1;
                    nextState = FILL;
                end
            end
            FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {addrTag, addrIdx, beat, 2'b00};
                if (mem_ready) begin
                    wordWe = 1'b1;
                    wrOff  = beat;
                    wrWord = mem_rdata;
                    // Tag and valid are committed only with the final word.
                    if (beat == '1) begin
                        lineWe    = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                stall   = !mem_ready;
                if (mem_ready) begin
                    wordWe    = hit;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped with a 2-cycle-latency memory.
module tb_dcache_direct_mapped;

    localparam int unsigned NLINES = 64;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned MEMW   = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    dcache_direct_mapped #(
        .LINES       (NLINES),
        .BLOCK_WORDS (NWORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seedWord(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Main memory model: ready two cycles after each beat's request starts.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beatT;

    beatT        beatLog [$];
    logic [1:0]  waitCnt = 2'd0;
    logic [31:0] memWr   [MEMW];
    bit          memHas  [MEMW];

    assign mem_ready = mem_req && (waitCnt == 2'd2);
    assign mem_rdata = memHas[mem_addr[13:2]] ? memWr[mem_addr[13:2]] : seedWord(int'(mem_addr[13:2]));

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            beatLog.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) begin
                memWr[mem_addr[13:2]]  <= mem_wdata;
                memHas[mem_addr[13:2]] <= 1'b1;
            end
        end
        if (mem_req && !mem_ready) waitCnt <= waitCnt + 2'd1;
        else                       waitCnt <= 2'd0;
    end

    // Reference: what memory should hold, and which line each index holds.
    logic [31:0] refWr    [MEMW];
    bit          refHas   [MEMW];
    bit          refValid [NLINES];
    int unsigned refTag   [NLINES];

    function automatic logic [31:0] refRead(input logic [31:0] addr);
        int unsigned w;
        w = int'(addr[13:2]);
        return refHas[w] ? refWr[w] : seedWord(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline request: hold it while stalled, then check latency, data and memory traffic.
    task automatic doOp(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input string name);
        int unsigned idx, tag, startLog, nBeats, expBeats, cycles, expStall;
        bit expHit;
        idx      = (addr / 16) % NLINES;
        tag      = addr / 1024;
        expHit   = refValid[idx] && refTag[idx] == tag;
        expStall = wr ? 3 : ((rd && !expHit) ? 1 + NWORDS * 3 : 0);
        expBeats = wr ? 1 : ((rd && !expHit) ? NWORDS : 0);
        startLog = beatLog.size();

        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = data;
        #1;
        cycles = 0;
        while (stall && cycles < 200) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        check($sformatf("%s stallCycles", name), cycles, expStall);
        if (rd && !wr) check($sformatf("%s rdata", name), cpu_rdata, refRead(addr));
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;

        nBeats = beatLog.size() - startLog;
        check($sformatf("%s beatCount", name), nBeats, expBeats);
        for (int unsigned i = 0; i < nBeats && i < expBeats; i++) begin
            if (wr) begin
                check($sformatf("%s wrWe", name), 32'(beatLog[startLog+i].we), 32'd1);
                check($sformatf("%s wrAddr", name), beatLog[startLog+i].addr, addr & ~32'h3);
                check($sformatf("%s wrData", name), beatLog[startLog+i].data, data);
            end else begin
                check($sformatf("%s fillWe", name), 32'(beatLog[startLog+i].we), 32'd0);
                check($sformatf("%s fillAddr%0d", name, i), beatLog[startLog+i].addr,
                      (addr & ~32'hF) + 4 * i);
            end
        end

        if (wr) begin
            refWr[addr[13:2]]  = data;
            refHas[addr[13:2]] = 1'b1;
        end else if (rd && !expHit) begin
            refValid[idx] = 1'b1;
            refTag[idx]   = tag;
        end
    endtask

    initial begin
        int unsigned startLog, guard, kind;
        logic [31:0] a;

        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int unsigned i = 0; i < NLINES; i++) refValid[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset memReq", 32'(mem_req), 32'd0);
        check("reset memWe", 32'(mem_we), 32'd0);

        doOp(1'b1, 1'b0, 32'h0000_0104, 32'h0, "coldMiss");
        doOp(1'b1, 1'b0, 32'h0000_010C, 32'h0, "readHit");
        doOp(1'b1, 1'b0, 32'h0000_0500, 32'h0, "conflictFill");
        doOp(1'b1, 1'b0, 32'h0000_0104, 32'h0, "evictedMiss");
        doOp(1'b0, 1'b1, 32'h0000_0108, 32'hDEAD_BEEF, "storeHit");
        doOp(1'b1, 1'b0, 32'h0000_0108, 32'h0, "storeReadback");
        doOp(1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, "storeMiss");
        doOp(1'b1, 1'b0, 32'h0000_2000, 32'h0, "missAfterStore");
        doOp(1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, "rdWrTogether");

        // Reset in the middle of a refill, after two beats have completed.
        startLog = beatLog.size();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 32'h0000_0400;
        guard = 0;
        while (beatLog.size() - startLog < 2 && guard < 100) begin
            guard++;
            @(posedge clk);
            #1;
        end
        check("midFill beatsSeen", beatLog.size() - startLog, 32'd2);
        check("midFill stall", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("afterReset memReq", 32'(mem_req), 32'd0);
        rst = 1'b0; cpu_rd = 1'b0;
        for (int unsigned i = 0; i < NLINES; i++) refValid[i] = 1'b0;
        doOp(1'b1, 1'b0, 32'h0000_0400, 32'h0, "refillAfterReset");

        // Randomized mix over a few tags and indices to force hits, misses and evictions.
        for (int unsigned n = 0; n < 80; n++) begin
            a = ($urandom_range(3) << 10) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2);
            kind = $urandom_range(3);
            case (kind)
                0, 1:    doOp(1'b1, 1'b0, a, 32'h0, $sformatf("rnd%0d rd", n));
                2:       doOp(1'b0, 1'b1, a, $urandom, $sformatf("rnd%0d wr", n));
                default: doOp(1'b1, 1'b1, a, $urandom, $sformatf("rnd%0d rdwr", n));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_direct_mapped.md
# dcache_direct_mapped

Direct-mapped, write-through, no-write-allocate data cache that sits between the pipeline's MEM stage and a slower handshaked main memory. It is the responder for the MEM stage's load/store requests and the initiator toward main memory. On a hit it answers in the same cycle. On a miss or store it raises `stall` until the access completes.

## Interface
Parameters:
- `LINES`, 64: number of cache lines; power of two, at least 2.
- `BLOCK_WORDS`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk`: in, 1. Rising-edge clock.
- `rst`: in, 1. Synchronous, active-high reset.
- `cpu_rd`: in, 1. Load request from the MEM stage.
- `cpu_wr`: in, 1. Store request from the MEM stage.
- `cpu_addr`: in, 32. Byte address; bits [1:0] are ignored.
- `cpu_wdata`: in, 32. Store data.
- `cpu_rdata`: out, 32. Load data; valid when `cpu_rd` is high and `stall` is low.
- `stall`: out, 1. Combinational. While high, the pipeline holds every stage.
- `mem_req`: out, 1. Main-memory request.
- `mem_we`: out, 1. High for a write, low for a read.
- `mem_addr`: out, 32. Word-aligned byte address.
- `mem_wdata`: out, 32. Write data.
- `mem_rdata`: in, 32. Read data; valid in the same cycle as `mem_ready`.
- `mem_ready`: in, 1. Completes the current beat; sampled only while `mem_req` is high.

## Operation
Address split, from LSB upward:
- 2 byte bits.
- `OFF = log2(BLOCK_WORDS)` word-offset bits.
- `IDX = log2(LINES)` index bits.
- Tag is the remaining `30-OFF-IDX` bits.

Storage: one valid bit, one tag and `BLOCK_WORDS` data words per line.

hit = valid[idx] && tag[idx] == addr tag.

FSM states:
- IDLE
  - `cpu_wr` → WRITE. `cpu_wr` has priority if `cpu_rd` is also high.
  - `cpu_rd` and miss → FILL, with beat counter = 0.
  - `cpu_rd` and hit → stay in IDLE; `cpu_rdata` = cached word.
  - Neither request → stay in IDLE.
- FILL
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr` = {tag, idx, beat, 2'b00}; beats run in order 0..`BLOCK_WORDS`-1.
  - On each `mem_ready`, store `mem_rdata` into word[beat], then increment beat.
  - On the last beat, write the tag, set valid, and go to IDLE.
- WRITE
  - `mem_req`=1, `mem_we`=1, `mem_addr`={`cpu_addr`[31:2],2'b00}, `mem_wdata`=`cpu_wdata`.
  - On `mem_ready`: if hit, update the cached word; if miss, no allocation. Then go to IDLE.

`stall` (combinational):
- In IDLE: `cpu_wr` | (`cpu_rd` & ~hit).
- In FILL: 1.
- In WRITE: ~`mem_ready`.

Outputs outside FILL/WRITE: `mem_req`=`mem_we`=0; `mem_addr` and `mem_wdata` are don't-care.

`cpu_rdata` when not a valid hit: don't-care. The bench must not check it then.

## Timing
- Reset:
  - All valid bits are cleared.
  - FSM = IDLE, beat = 0.
  - `mem_req`=0, `mem_we`=0.
  - `stall` reflects the IDLE equation on the first post-reset cycle.
  - Tag and data arrays are not reset.
- Read hit: 0 stall cycles; data is available combinationally in the request cycle.
- Read miss:
  - The request cycle stalls.
  - FILL takes one cycle per beat with zero-wait memory, more if `mem_ready` is late.
  - The cycle after the last beat is IDLE with a hit, so `stall` drops.
  - Total stall = 1 + Σ(beat latencies) cycles; 5 cycles for `BLOCK_WORDS`=4 with zero-wait memory.
- Store: the request cycle stalls, then WRITE. `stall` drops in the cycle `mem_ready` is seen, and the pipeline advances on that edge.
- Requests must be held stable while `stall` is high. `cpu_addr` changes mid-miss are undefined.
- Reset during FILL aborts the refill. Because valid is written only on the last beat, no partial line ever becomes valid.
- Reset during WRITE aborts it; the memory-side beat may or may not have completed.
- `mem_ready` outside FILL/WRITE is ignored.

## Structure
- Shared package `dcache_pkg`:
  - State enum {IDLE, FILL, WRITE}.
  - Address-field width functions derived from `LINES`/`BLOCK_WORDS`.
  - Word width constant 32.
- One natural sub-module, `dcache_array`:
  - Valid/tag/data storage.
  - Combinational read port for tag, valid and word.
  - Synchronous write port for word, tag and valid, plus valid clear on `rst`.
- FSM, beat counter and hit compare live in the top.

## Test plan
Memory model: `mem_ready` asserted 2 cycles after `mem_req` rises, per beat. `BLOCK_WORDS`=4, `LINES`=64.
- Cold read miss: after reset, `cpu_rd` @0x00000104 → four reads at 0x100, 0x104, 0x108, 0x10C; `stall` high for 1+4×3=13 cycles; `cpu_rdata` = memory word at 0x104.
- Read hit: then `cpu_rd` @0x0000010C → `stall`=0 and data returned in the same cycle; `mem_req` stays 0.
- Conflict eviction: `cpu_rd` @0x00000500 maps to the same index as 0x100 → refill. A subsequent read of 0x104 misses again.
- Store hit then miss:
  - `cpu_wr` 0xDEADBEEF @0x108 while the line is resident → one memory write, cache updated; read of 0x108 returns 0xDEADBEEF with no refill.
  - `cpu_wr` @0x2000 (not resident) → memory write only; a following read of 0x2000 misses.
- Simultaneous `cpu_rd`&`cpu_wr` @0x300 → handled as a write; exactly one `mem_req` with `mem_we`=1.
- Reset mid-refill: assert `rst` after beat 2 of a miss @0x400 → `mem_req` is 0 the next cycle; a later read of 0x400 misses and does a full 4-beat refill.
